// File: rtl/seq_detector_mealy_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_mealy_if
//  Description : Serial stream / detector status bundle for seq_detector_mealy.
//                The master drives the serial stream and enable. The slave
//                (the detector) returns the match pulse, hit count and busy.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_detector_mealy_if #(
    parameter int COUNT_W = 8
);
    logic               en;
    logic               din_valid;
    logic               din;
    logic               dout;
    logic [COUNT_W-1:0] match_count;
    logic               busy;

    modport master (
        output en, din_valid, din,
        input  dout, match_count, busy
    );

    modport slave (
        input  en, din_valid, din,
        output dout, match_count, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_detector_mealy.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_mealy
//  Description : Parametrised serial sequence detector (Mealy FSM, IDLE/RUN).
//                Flags each completed PATTERN on the cycle its last bit
//                arrives, with overlapping or restarting detection and a
//                saturating hit counter.
//                Optional macro SEQ_DET_REG_OUT_EN: registers dout, so each
//                pulse appears one cycle after the final bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_mealy #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter int                     OVERLAP     = 1,
    parameter int                     COUNT_W     = 8
) (
    input  wire                   clk,
    input  wire                   rst,
    seq_detector_mealy_if.slave   bus
);

    // cnt must hold 0 .. PATTERN_LEN-1
    localparam int                 c_CNT_W   = $clog2(PATTERN_LEN);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(PATTERN_LEN - 1);
    localparam logic [COUNT_W-1:0] c_HIT_MAX = {COUNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [PATTERN_LEN-2:0]   r_hist;
    logic [c_CNT_W-1:0]       r_cnt;
    logic [COUNT_W-1:0]       r_match_count;
    logic                     w_accept;
    logic                     w_match;
    logic [PATTERN_LEN-1:0]   w_window;

    // The candidate window: stored history followed by the incoming bit.
    // Its low PATTERN_LEN-1 bits are also the next history, which covers
    // PATTERN_LEN=2 without a special case.
    assign w_window = {r_hist, bus.din};
    assign w_accept = (r_state == RUN) && bus.en && bus.din_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and the Mealy match output; reset masks a completing window
    always_comb begin
        w_state_next = IDLE;
        w_match      = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = bus.en ? RUN : IDLE;
            end
            RUN: begin
                w_state_next = bus.en ? RUN : IDLE;
                w_match      = !rst && w_accept && (r_cnt == c_CNT_MAX)
                               && (w_window == PATTERN);
            end
            default: begin
                w_state_next = IDLE;
                w_match      = 1'b0;
            end
        endcase
    end

    // History shift register and valid-bit count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_cnt  <= '0;
        end else if (r_state == RUN && !bus.en) begin
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_hist <= w_window[PATTERN_LEN-2:0];
            if (w_match && (OVERLAP == 0)) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Saturating hit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match_count <= '0;
        end else if (w_match && (r_match_count != c_HIT_MAX)) begin
            r_match_count <= r_match_count + 1'b1;
        end
    end

`ifdef SEQ_DET_REG_OUT_EN
    logic r_dout;

    // Glitch-free registered match pulse, one cycle after the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= 1'b0;
        end else begin
            r_dout <= w_match;
        end
    end

    assign bus.dout = r_dout;
`else
    assign bus.dout = w_match;
`endif

    assign bus.match_count = r_match_count;
    assign bus.busy        = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_mealy.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detector_mealy
//  Description : Directed bench for seq_detector_mealy. Three instances share
//                one stimulus stream: overlapping (COUNT_W=8), restarting
//                (COUNT_W=8) and restarting with a 2-bit saturating counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_mealy;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic dv  = 1'b0;
    logic di  = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    int exp_cnt_ov  = 0;
    int exp_cnt_nov = 0;
    int exp_cnt_sat = 0;

    typedef struct {
        string tag;
        bit    xo;
        bit    xn;
    } exp_t;

    exp_t sb[$];

    seq_detector_mealy_if #(.COUNT_W(8)) if_ov  ();
    seq_detector_mealy_if #(.COUNT_W(8)) if_nov ();
    seq_detector_mealy_if #(.COUNT_W(2)) if_sat ();

    assign if_ov.en         = en;
    assign if_ov.din_valid  = dv;
    assign if_ov.din        = di;
    assign if_nov.en        = en;
    assign if_nov.din_valid = dv;
    assign if_nov.din       = di;
    assign if_sat.en        = en;
    assign if_sat.din_valid = dv;
    assign if_sat.din       = di;

    seq_detector_mealy #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .COUNT_W(8))
        u_ov  (.clk(clk), .rst(rst), .bus(if_ov));
    seq_detector_mealy #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .COUNT_W(8))
        u_nov (.clk(clk), .rst(rst), .bus(if_nov));
    seq_detector_mealy #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .COUNT_W(2))
        u_sat (.clk(clk), .rst(rst), .bus(if_sat));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pop_dout();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard: observed empty expected entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "/dout_ov"},  int'(if_ov.dout),  int'(e.xo));
            chk({e.tag, "/dout_nov"}, int'(if_nov.dout), int'(e.xn));
            chk({e.tag, "/dout_sat"}, int'(if_sat.dout), int'(e.xn));
        end
    endtask

    // One clock of stimulus. xo/xn: expected match for overlap / restart
    // instances on this cycle's input. xb: expected busy, -1 = don't care.
    task automatic step(input bit r, input bit e, input bit v, input bit d,
                        input bit xo, input bit xn, input int xb, input string tag);
        exp_t it;
        @(negedge clk);
        rst = r;
        en  = e;
        dv  = v;
        di  = d;
        it.tag = tag;
        it.xo  = xo;
        it.xn  = xn;
        sb.push_back(it);
        #1;
        if (xb >= 0) begin
            chk({tag, "/busy"}, int'(if_ov.busy),  xb);
            chk({tag, "/busy"}, int'(if_nov.busy), xb);
        end
`ifndef SEQ_DET_REG_OUT_EN
        pop_dout();
`endif
        @(posedge clk);
        #1;
`ifdef SEQ_DET_REG_OUT_EN
        pop_dout();
`endif
        if (r) begin
            exp_cnt_ov  = 0;
            exp_cnt_nov = 0;
            exp_cnt_sat = 0;
        end else begin
            if (xo && exp_cnt_ov  < 255) exp_cnt_ov++;
            if (xn && exp_cnt_nov < 255) exp_cnt_nov++;
            if (xn && exp_cnt_sat < 3)   exp_cnt_sat++;
        end
        chk({tag, "/cnt_ov"},  int'(if_ov.match_count),  exp_cnt_ov);
        chk({tag, "/cnt_nov"}, int'(if_nov.match_count), exp_cnt_nov);
        chk({tag, "/cnt_sat"}, int'(if_sat.match_count), exp_cnt_sat);
    endtask

    // Feed n valid bits MSB-first with en=1; mo/mn mark expected hits per bit.
    task automatic feed(input bit [7:0] bits, input int n,
                        input bit [7:0] mo, input bit [7:0] mn, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, 1'b1, 1'b1, bits[i], mo[i], mn[i], 1, tag);
        end
    endtask

    task automatic gap3(input string tag);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, tag);
        end
    endtask

    initial begin
        // Power-up reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, "rst0");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, "rst1");

        // Reset mid-stream after 1,0,1
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, "go0");
        feed(8'b101, 3, 8'b000, 8'b000, "pre_rst");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, "rst_mid0");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, "rst_mid1");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, "rel_idle");
        feed(8'b011, 3, 8'b000, 8'b000, "post_rst");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, "stop0");

        // Overlap vs restart: 1,0,1,1,0,1,1
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, "go1");
        feed(8'b1011011, 7, 8'b0001001, 8'b0001000, "ovl");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, "stop1");

        // din_valid gaps between 1,0,1,1
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, "go2");
        feed(8'b1, 1, 8'b0, 8'b0, "gap_b1");
        gap3("gap_a");
        feed(8'b0, 1, 8'b0, 8'b0, "gap_b2");
        gap3("gap_b");
        feed(8'b1, 1, 8'b0, 8'b0, "gap_b3");
        gap3("gap_c");
        feed(8'b1, 1, 8'b1, 8'b1, "gap_b4");

        // Enable drop after 1,0,1 then a fresh 1,0,1,1
        feed(8'b101, 3, 8'b000, 8'b000, "drop_pre");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, "drop_en0");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, "drop_idle");
        feed(8'b1011, 4, 8'b0001, 8'b0001, "drop_post");

        // Two more hits: 2-bit counter holds at 3
        feed(8'b10111011, 8, 8'b00010001, 8'b00010001, "sat");

        // Final reset clears the counters
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "rst_end");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "post_end");

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_detector_mealy.md
Name: seq_detector_mealy

Overview:
Parametrised serial sequence detector built as a Mealy FSM. It generalises the fixed 1-bit idle/s0/s1 detector to a configurable bit pattern of configurable length. Overlapping or non-overlapping detection is selectable, and a saturating hit counter is included. It sits on a serial input stream and flags each completed pattern on the same cycle the final bit arrives.

Parameters:
PATTERN_LEN, 4, pattern length in bits; legal range is 2 to 32.
PATTERN, 4'b1011, target sequence; the MSB is the first bit received.
OVERLAP, 1, 1 means overlapping detection and 0 means the window restarts after each hit.
COUNT_W, 8, width of the hit counter.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
en  input  1  detector enable
din_valid  input  1  din carries a bit this cycle
din  input  1  serial data bit
dout  output  1  match pulse (Mealy, combinational from state/din)
match_count  output  COUNT_W  number of hits, saturating
busy  output  1  high while the FSM is in RUN

Behaviour:
- Reset: rst is synchronous and active-high, sampled on posedge clk.
  - State goes to IDLE; hist and cnt are cleared.
  - match_count is cleared; dout=0 and busy=0.
  - A reset mid-stream discards any partial match.
- State register: two states, IDLE and RUN.
  - The next state and dout come from one combinational process over state, en, din_valid, din, hist and cnt.
  - Any illegal state encoding goes to IDLE with dout=0.
- IDLE:
  - dout=0.
  - en=1 moves to RUN on the next edge.
  - Bits presented while in IDLE are ignored, including on the transition cycle.
- RUN:
  - en=0 returns the FSM to IDLE on the next edge and clears cnt.
  - dout=0 in any cycle with en=0.
- Bit acceptance: a bit is accepted when state==RUN, en=1 and din_valid=1. When din_valid=0, nothing changes.
- Datapath state:
  - hist[PATTERN_LEN-2:0] is a shift register of previous bits; the newest bit is in the LSB.
  - cnt holds the number of valid history bits, 0 to PATTERN_LEN-1.
- Match condition: match = accepted && cnt==PATTERN_LEN-1 && {hist,din}==PATTERN.
  - dout=match in the same cycle (zero latency).
- Update on an accepted bit:
  - hist <= {hist[PATTERN_LEN-3:0],din}. When PATTERN_LEN=2, hist <= din.
  - cnt <= min(cnt+1, PATTERN_LEN-1).
- On a match with OVERLAP=0: cnt <= 0 instead. The next match needs PATTERN_LEN fresh bits.
- On a match with OVERLAP=1: the normal update applies, so a suffix of the pattern can start the next match.
- match_count increments by 1 on each match and holds at 2^COUNT_W-1 (no wrap).
- busy = (state==RUN).

Optional Feature:
Macro: SEQ_DET_REG_OUT_EN.
- Defined: dout is a flop that captures match. Each pulse appears exactly one cycle after the final bit, and dout is glitch-free. The flop resets to 0.
- Not defined: dout is the pure Mealy combinational output, as described above.
- match_count timing is identical in both builds.

Test Plan:
All scenarios use the default parameters (PATTERN=4'b1011) unless a different value is stated.
- Reset: assert rst for 2 cycles mid-stream after bits 1,0,1. Then release rst and set en=1 and din_valid=1, and feed 1. Required: dout=0, match_count=0, and one IDLE cycle before RUN.
- Overlap, OVERLAP=1: stream 1,0,1,1,0,1,1 with din_valid always 1. Required: dout=1 on bits 4 and 7 only; match_count=2.
- Non-overlap, OVERLAP=0: same stream 1,0,1,1,0,1,1. Required: dout=1 on bit 4 only; match_count=1.
- Valid gaps: stream 1,0,1,1 with din_valid=0 gaps of 3 cycles between bits. Required: dout=1 only in the cycle of the 4th valid bit; dout=0 during the gaps.
- Enable drop: feed 1,0,1, drop en for 1 cycle, then feed 1. Required: no match and busy=0 for one cycle. Feeding 1,0,1,1 afterwards gives dout=1.
- Saturation: COUNT_W=2, 5 non-overlapping matches. Required: match_count goes 1,2,3,3,3. With SEQ_DET_REG_OUT_EN defined, each dout pulse is delayed by exactly 1 cycle.
